// File: rtl/lsb_diff_unit.sv
// lsb_diff_unit: execution unit for the `diff` instruction.
// Reports the bit index of the lowest position where A and B differ,
// or 32 (with equal = 1) when the operands are identical. The XOR and
// priority encoder are combinational; out, equal and out_valid are
// driven directly from one register stage.
module lsb_diff_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic [31:0] out,
  output logic        equal,
  output logic        out_valid
);

  // Priority encoder: index of the lowest set bit, 6'd32 when none is set.
  // The scan runs from the top down so the lowest set bit is written last
  // and wins.
  function automatic logic [5:0] lowest_set_idx(input logic [31:0] vec);
    logic [5:0] idx;
    idx = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 6'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [31:0] diff_s;
  logic [5:0]  idx_s;
  logic        same_s;
  logic [31:0] result_s;

  logic [31:0] out_r;
  logic        equal_r;
  logic        out_valid_r;

  // Difference vector, lowest differing bit index and the equal flag.
  always_comb begin
    diff_s   = 32'h0000_0000;
    idx_s    = 6'd0;
    same_s   = 1'b0;
    result_s = 32'h0000_0000;
    diff_s   = A ^ B;
    idx_s    = lowest_set_idx(diff_s);
    if (diff_s == 32'h0000_0000) begin
      same_s   = 1'b1;
      result_s = 32'h0000_0020;
    end else begin
      same_s   = 1'b0;
      result_s = {26'd0, idx_s};
    end
  end

  // Result register: capture on in_valid, hold otherwise; valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= 32'h0000_0000;
      equal_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        out_r   <= result_s;
        equal_r <= same_s;
      end else begin
        out_r   <= out_r;
        equal_r <= equal_r;
      end
    end
  end

  assign out       = out_r;
  assign equal     = equal_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_lsb_diff_unit.sv
// Self-checking bench for lsb_diff_unit: directed cases plus a randomized
// stream compared against a trailing-zero-count reference model.
module tb_lsb_diff_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        in_valid;
  logic [31:0] out;
  logic        equal;
  logic        out_valid;

  int checks;
  int errors;

  // Reference-model view of what the registered outputs should hold.
  logic [31:0] exp_out;
  logic        exp_eq;
  logic        exp_vld;

  lsb_diff_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .out       (out),
    .equal     (equal),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count trailing zeros of A^B by shifting; 32 when equal.
  function automatic logic [31:0] ref_idx(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    int n;
    x = a ^ b;
    if (x == 32'd0) return 32'd32;
    n = 0;
    while (x[0] == 1'b0) begin
      x = x >> 1;
      n++;
    end
    return 32'(n);
  endfunction

  // Drive one pair at the falling edge, clock it in, and advance the model.
  // Returns 1 ns after the rising edge, when outputs are safe to sample.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic v);
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = v;
    @(posedge clk);
    if (rst_n) begin
      exp_vld = v;
      if (v) begin
        exp_out = ref_idx(a, b);
        exp_eq  = (a == b);
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    A        = 32'd1;
    B        = 32'd2;
    in_valid = 1'b1;
    exp_out  = 32'd0;
    exp_eq   = 1'b0;
    exp_vld  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 32'd0 || equal !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out=%0d equal=%0b out_valid=%0b, want 0 0 0", out, equal, out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    // Load a non-zero result, then assert reset mid-cycle.
    drive(32'd4, 32'd8, 1'b1);
    checks++;
    if (out !== 32'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: out=%0d out_valid=%0b, want 2 1", out, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 32'd0 || equal !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%0d equal=%0b out_valid=%0b, want 0 0 0", out, equal, out_valid);
    end
    exp_out = 32'd0;
    exp_eq  = 1'b0;
    exp_vld = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic [31:0] want_out [7];
    logic        want_eq [7];
    ta = '{32'd63, 32'd4, 32'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0001_0000};
    tb = '{32'd96, 32'd8, 32'd4, 32'd0,         32'hFFFF_FFFE, 32'd0, 32'h0000_0000};
    want_out = '{32'd0, 32'd2, 32'd32, 32'd31, 32'd0, 32'd32, 32'd16};
    want_eq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(ta[i], tb[i], 1'b1);
      checks++;
      if (out !== want_out[i] || equal !== want_eq[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d: A=%h B=%h out=%0d equal=%0b out_valid=%0b, want %0d %0b 1",
                 i, ta[i], tb[i], out, equal, out_valid, want_out[i], want_eq[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] sa [5];
    logic [31:0] sb [5];
    logic        sv [5];
    logic [31:0] want_out [5];
    logic        want_vld [5];
    sa = '{32'd63, 32'd4, 32'd4, 32'd1, 32'd7};
    sb = '{32'd96, 32'd8, 32'd4, 32'd0, 32'd0};
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    want_out = '{32'd0, 32'd2, 32'd32, 32'd32, 32'd32};
    want_vld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(sa[i], sb[i], sv[i]);
      checks++;
      if (out !== want_out[i] || out_valid !== want_vld[i]) begin
        errors++;
        $display("FAIL stream_%0d: out=%0d out_valid=%0b, want %0d %0b",
                 i, out, out_valid, want_out[i], want_vld[i]);
      end
    end
    // Operand changes while idle must not disturb the held result.
    A = 32'h1234_5678;
    B = 32'h0;
    #3;
    checks++;
    if (out !== 32'd32 || equal !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: out=%0d equal=%0b, want 32 1", out, equal);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] mask;
    logic        v;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 15) == 0) mask = 32'd0;
      else mask = $urandom << $urandom_range(0, 31);
      v = ($urandom_range(0, 3) != 0);
      drive(a, a ^ mask, v);
      checks++;
      if (out !== exp_out || equal !== exp_eq || out_valid !== exp_vld) begin
        errors++;
        $display("FAIL random_%0d: A=%h B=%h v=%0b out=%0d equal=%0b out_valid=%0b, want %0d %0b %0b",
                 i, a, a ^ mask, v, out, equal, out_valid, exp_out, exp_eq, exp_vld);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsb_diff_unit.md
# lsb_diff_unit

Combinational-core, registered-output execution unit for the KGP-miniRISC `diff` instruction. It reports the bit position of the least significant bit where two 32-bit operands differ. It sits beside the ALU in the execute stage, and its result is written back like any other ALU result. It adds one pipeline register stage with valid tracking.

## Interface
- No parameters; operand width is fixed at 32.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  32  first operand (unsigned bit vector).
- B  input  32  second operand (unsigned bit vector).
- in_valid  input  1  A/B are sampled on this clock edge.
- out  output  32  registered result: index of the lowest differing bit, zero-extended.
- equal  output  1  registered flag; 1 when A == B for the sampled pair.
- out_valid  output  1  registered; 1 for exactly the cycle following an accepted in_valid.

## Operation
- Difference vector: X = A XOR B.
- The result is the index i (0..31) of the lowest set bit of X, using a 32-input priority encoder with the lowest index winning.
- If X == 0 (operands identical):
  - out = 32 (32'h0000_0020).
  - equal = 1.
- Otherwise equal = 0, and out[31:5] = 0, so the index sits in out[4:0].
- The result is purely a function of the operands sampled in the same cycle; there is no history or accumulation.
- When in_valid = 0, out and equal hold their previous values, and out_valid = 0.
- There is no back-pressure. The unit accepts a new pair every cycle.
- Reset (rst_n = 0, asynchronous):
  - out = 0, equal = 0, out_valid = 0 immediately, independent of clk.
  - A pair presented during reset is discarded.
  - The first valid result can appear no earlier than the cycle after the first rising edge with rst_n = 1 and in_valid = 1.

## Timing
- Latency: exactly 1 cycle. A pair is sampled at edge N, and out, equal and out_valid are valid after edge N, until edge N+1.
- Throughput: one result per cycle. Back-to-back in_valid produces back-to-back out_valid, each result matching its own input pair.
- Combinational path: XOR, then a 32-bit priority encoder, then the register. No logic sits between the registers and the outputs.
- Reset assertion mid-stream clears any in-flight result; no result is produced for a pair sampled on the same edge reset is released.
- Outputs are stable between clock edges; A/B changes with in_valid = 0 have no effect on the outputs.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with out holding a non-zero value -> out = 0, equal = 0, out_valid = 0 immediately, without waiting for a clock edge.
- A = 63, B = 96, in_valid = 1 -> X = 0x3F ^ 0x60 = 0x5F; next cycle out = 0, equal = 0, out_valid = 1.
- A = 4, B = 8 -> next cycle out = 2, equal = 0.
- A = 4, B = 4 -> next cycle out = 32, equal = 1.
- Extremes:
  - A = 0x8000_0000, B = 0 -> out = 31.
  - A = 0xFFFF_FFFF, B = 0xFFFF_FFFE -> out = 0.
  - A = 0, B = 0 -> out = 32, equal = 1.
- Streaming: back-to-back pairs (63, 96), (4, 8), (4, 4), then in_valid = 0 for 2 cycles:
  - out_valid pattern 1, 1, 1, 0, 0.
  - out sequence 0, 2, 32, then holds 32 while out_valid = 0.
  - Random-compare 10k pairs against a reference lowest-set-bit model.
